msrv32_alu_arbiter: RTL and testbench

- Shares the single combinational msrv32 ALU between two requesters: req0 (integer execute) and req1 (address/branch-compare helper).
- Round-robin arbitration, valid/ready handshake on each request port, single-entry registered response buffer.
- Sits between the requesters and the ALU; drives the ALU operand and opcode inputs and captures the ALU result one cycle later.

---
 rtl/msrv32_alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_msrv32_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_arbiter.sv
// msrv32_alu_arbiter
//
// Shares one combinational msrv32 ALU between two requesters:
//   req0 - integer execute
//   req1 - address / branch-compare helper
//
// The two requesters are arbitrated round-robin. The winner's operands and
// opcode go straight to the ALU. On accept, the ALU result is captured into a
// single-entry response buffer and appears on the response port one cycle
// later. If the consumer drains the buffer in the same cycle as a new accept,
// the buffer is overwritten, so one response per cycle can be sustained.
//
// Parameters:
//   WIDTH      - operand / result width
//   FIRST_PRIO - requester that wins the first tie after reset
//
// Ports:
//   ms_riscv32_mp_clk_in    clock
//   ms_riscv32_mp_rst_n_in  asynchronous active-low reset
//   reqN_valid_in / reqN_op1_in / reqN_op2_in / reqN_opcode_in
//                           request N (N = 0, 1)
//   reqN_ready_out          request N accepted this cycle
//   alu_op1_out / alu_op2_out / alu_opcode_out
//                           ALU operand and opcode drive
//   alu_result_in           ALU result (combinational)
//   rsp_valid_out / rsp_id_out / rsp_result_out
//                           registered response
//   rsp_ready_in            response consumer ready
//   rsp_err_out             illegal-opcode flag (optional, see below)
//
// Optional feature: define MSRV32_ALU_ARB_ILLEGAL_CHK_EN to add rsp_err_out.
// An accepted illegal opcode then returns result 0 with rsp_err_out = 1.

module msrv32_alu_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          FIRST_PRIO = 1'b0
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_n_in,
    input  logic             req0_valid_in,
    input  logic [WIDTH-1:0] req0_op1_in,
    input  logic [WIDTH-1:0] req0_op2_in,
    input  logic [3:0]       req0_opcode_in,
    output logic             req0_ready_out,
    input  logic             req1_valid_in,
    input  logic [WIDTH-1:0] req1_op1_in,
    input  logic [WIDTH-1:0] req1_op2_in,
    input  logic [3:0]       req1_opcode_in,
    output logic             req1_ready_out,
    output logic [WIDTH-1:0] alu_op1_out,
    output logic [WIDTH-1:0] alu_op2_out,
    output logic [3:0]       alu_opcode_out,
    input  logic [WIDTH-1:0] alu_result_in,
    output logic             rsp_valid_out,
    output logic             rsp_id_out,
    output logic [WIDTH-1:0] rsp_result_out,
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
    output logic             rsp_err_out,
`endif
    input  logic             rsp_ready_in
);

    typedef enum logic {StEmpty, StFull} buf_state_e;

    buf_state_e state_q;
    logic       last_grant_q;

    logic any_valid;
    logic winner;
    logic can_accept;
    logic accept;

`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
    function automatic logic opcode_legal(input logic [3:0] op);
        logic legal;
        unique case (op)
            4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
            4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction
`endif

    // Round-robin: a lone requester always wins; on a tie the requester
    // that was not granted last time wins.
    always_comb begin
        any_valid = req0_valid_in | req1_valid_in;
        if (req0_valid_in && req1_valid_in) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1_valid_in;
        end
    end

    // The buffer can take a new result when empty, or when its current
    // content is being drained this very cycle.
    assign can_accept = (state_q == StEmpty) | (rsp_ready_in & rsp_valid_out);
    assign accept     = any_valid & can_accept;

    assign req0_ready_out = accept & ~winner;
    assign req1_ready_out = accept & winner;

    // The winner drives the ALU even when blocked; the result is then dropped.
    always_comb begin
        alu_op1_out    = '0;
        alu_op2_out    = '0;
        alu_opcode_out = 4'b0000;
        if (any_valid) begin
            if (winner) begin
                alu_op1_out    = req1_op1_in;
                alu_op2_out    = req1_op2_in;
                alu_opcode_out = req1_opcode_in;
            end else begin
                alu_op1_out    = req0_op1_in;
                alu_op2_out    = req0_op2_in;
                alu_opcode_out = req0_opcode_in;
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q        <= StEmpty;
            last_grant_q   <= ~FIRST_PRIO;
            rsp_valid_out  <= 1'b0;
            rsp_id_out     <= 1'b0;
            rsp_result_out <= '0;
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
            rsp_err_out    <= 1'b0;
`endif
        end else if (accept) begin
            state_q        <= StFull;
            last_grant_q   <= winner;
            rsp_valid_out  <= 1'b1;
            rsp_id_out     <= winner;
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
            if (opcode_legal(alu_opcode_out)) begin
                rsp_result_out <= alu_result_in;
                rsp_err_out    <= 1'b0;
            end else begin
                rsp_result_out <= '0;
                rsp_err_out    <= 1'b1;
            end
`else
            rsp_result_out <= alu_result_in;
`endif
        end else if (rsp_valid_out && rsp_ready_in) begin
            // Drain only; id and result keep their last values.
            state_q       <= StEmpty;
            rsp_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Testbench for msrv32_alu_arbiter: directed scenarios followed by random
// traffic, with expected responses queued by a stimulus-side model and checked
// by an independent response monitor.
module tb_msrv32_alu_arbiter;

    localparam int unsigned W  = 32;
    localparam bit          FP = 1'b0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [3:0]   req0_opc = '0, req1_opc = '0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] alu_op1, alu_op2, alu_result;
    logic [3:0]   alu_opc;
    logic         rsp_valid, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_ready = 1'b0;
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
    logic         rsp_err;
`endif

    always #5 clk = ~clk;

    msrv32_alu_arbiter #(.WIDTH(W), .FIRST_PRIO(FP)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .req0_valid_in          (req0_valid),
        .req0_op1_in            (req0_op1),
        .req0_op2_in            (req0_op2),
        .req0_opcode_in         (req0_opc),
        .req0_ready_out         (req0_ready),
        .req1_valid_in          (req1_valid),
        .req1_op1_in            (req1_op1),
        .req1_op2_in            (req1_op2),
        .req1_opcode_in         (req1_opc),
        .req1_ready_out         (req1_ready),
        .alu_op1_out            (alu_op1),
        .alu_op2_out            (alu_op2),
        .alu_opcode_out         (alu_opc),
        .alu_result_in          (alu_result),
        .rsp_valid_out          (rsp_valid),
        .rsp_id_out             (rsp_id),
        .rsp_result_out         (rsp_result),
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
        .rsp_err_out            (rsp_err),
`endif
        .rsp_ready_in           (rsp_ready)
    );

    // Behavioural ALU; illegal codes return a recognisable junk value.
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b1101: return W'($signed(a) >>> b[4:0]);
            default: return a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                          4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
    endfunction

    assign alu_result = alu_ref(alu_op1, alu_op2, alu_opc);

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   last_grant;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Response monitor: the buffer must present the oldest unconsumed accept.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                    chk("rsp_result", rsp_result, exp_q[0].res);
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
                    chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
`endif
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus plus the arbitration/ALU-drive checks for it.
    task automatic step(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [3:0] o0, input bit v1, input logic [W-1:0] a1,
                        input logic [W-1:0] b1, input logic [3:0] o1, input bit rr);
        int   cand[$];
        int   win;
        bit   granted;
        rsp_t r;
        logic [W-1:0] ea, eb;
        logic [3:0]   eo;
        @(negedge clk);
        req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_opc = o0;
        req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_opc = o1;
        rsp_ready  = rr;
        #3;
        if (v0) cand.push_back(0);
        if (v1) cand.push_back(1);
        win = 0;
        if (cand.size() == 1) win = cand[0];
        else if (cand.size() == 2) win = last_grant ? 0 : 1;
        // Buffer has room once everything previously accepted has been consumed.
        granted = (cand.size() > 0) && (exp_q.size() == 0);
        chk("req0_ready", 32'(req0_ready), 32'(granted && win == 0));
        chk("req1_ready", 32'(req1_ready), 32'(granted && win == 1));
        ea = '0; eb = '0; eo = '0;
        if (cand.size() > 0) begin
            ea = win ? a1 : a0;
            eb = win ? b1 : b0;
            eo = win ? o1 : o0;
        end
        chk("alu_op1", alu_op1, ea);
        chk("alu_op2", alu_op2, eb);
        chk("alu_opcode", 32'(alu_opc), 32'(eo));
        if (granted) begin
            r.id  = 1'(win);
            r.res = alu_ref(ea, eb, eo);
            r.err = 1'b0;
`ifdef MSRV32_ALU_ARB_ILLEGAL_CHK_EN
            if (!is_legal(eo)) begin
                r.res = '0;
                r.err = 1'b1;
            end
`endif
            exp_q.push_back(r);
            last_grant = (win == 1);
        end
    endtask

    task automatic idle(input bit rr);
        step(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    logic [3:0] ops [10] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                             4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};

    initial begin
        logic [3:0] o0, o1;
        last_grant = !FP;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // req0 ADD 5+3 straight after reset, then drain.
        step(1, 5, 3, 4'b0000, 0, 0, 0, 0, 1);
        idle(1);
        idle(1);

        // Both valid every cycle: grants alternate with no bubbles.
        repeat (6) step(1, 10, 4, 4'b1000, 1, 32'hF0, 32'hFF, 4'b0100, 1);
        idle(1);
        idle(1);

        // Backpressure: buffer holds 8 while req1 waits, then both move together.
        step(1, 5, 3, 4'b0000, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 7, 9, 4'b0110, 0);
        step(0, 0, 0, 0, 1, 7, 9, 4'b0110, 1);
        idle(1);
        idle(1);

        // Illegal opcode on req1, then a legal signed SLT.
        step(0, 0, 0, 0, 1, 32'h1234, 32'h5678, 4'b1111, 1);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 4'b0010, 1);
        idle(1);
        idle(1);

        // Asynchronous reset while FULL.
        step(0, 0, 0, 0, 1, 2, 2, 4'b0000, 0);
        @(posedge clk);
        #2;
        chk("full_before_reset", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_id", 32'(rsp_id), 32'd0);
        chk("async_rst_result", rsp_result, 32'd0);
        mon_en = 1'b0;
        exp_q.delete();
        last_grant = !FP;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(1, 1, 1, 4'b0000, 1, 2, 2, 4'b0000, 1);
        step(1, 1, 1, 4'b0000, 1, 2, 2, 4'b0000, 1);
        idle(1);

        // Random traffic with occasional illegal opcodes and backpressure.
        for (int i = 0; i < 400; i++) begin
            o0 = ($urandom_range(0, 9) == 0) ? 4'(32'hF) : ops[$urandom_range(0, 9)];
            o1 = ($urandom_range(0, 9) == 0) ? 4'b1110 : ops[$urandom_range(0, 9)];
            step(1'($urandom_range(0, 1)), $urandom, $urandom, o0,
                 1'($urandom_range(0, 1)), $urandom, $urandom, o1,
                 $urandom_range(0, 3) != 0);
        end
        repeat (3) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
